// File: rtl/pc.sv
// Program counter for the fdt16 fetch stage: increment, stall, branch, with a
// registered output. Defining PC_RAS_EN adds a circular return-address stack.
module pc #(
   parameter int ADDR_W     = 9,
   parameter int RESET_ADDR = 0,
   parameter int RAS_DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] branch_address,
   input  logic              branch,
   input  logic              stall,
`ifdef PC_RAS_EN
   input  logic              call,
   input  logic              ret,
   output logic              ras_empty,
   output logic              ras_full,
`endif
   output logic [ADDR_W-1:0] pc_out,
   output logic [ADDR_W-1:0] pc_plus1
);

   localparam logic [ADDR_W-1:0] RESET_VAL = ADDR_W'(RESET_ADDR);

   if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pc: RAS_DEPTH must be a power of two and at least 2");
   end

   logic [ADDR_W-1:0] next_pc;

   assign pc_plus1 = pc_out + ADDR_W'(1);

`ifdef PC_RAS_EN
   localparam int PTR_W = $clog2(RAS_DEPTH);

   logic [ADDR_W-1:0] stack [RAS_DEPTH];
   logic [PTR_W-1:0]  top;
   logic [PTR_W:0]    count;
   logic              do_pop;
   logic              do_push;

   // A return on an empty stack is simply ignored; return beats call.
   assign do_pop    = ret && (count != '0);
   assign do_push   = call && !do_pop;
   assign ras_empty = (count == '0);
   assign ras_full  = (count == (PTR_W+1)'(RAS_DEPTH));

   // top is the next write slot; when full it also marks the oldest entry,
   // so a push there overwrites the oldest return address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         top   <= '0;
         count <= '0;
      end else if (do_pop) begin
         top   <= top - PTR_W'(1);
         count <= count - (PTR_W+1)'(1);
      end else if (do_push) begin
         top <= top + PTR_W'(1);
         if (!ras_full) count <= count + (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) stack[top] <= pc_plus1;
   end
`endif

   // Later assignments take priority: ret > call > branch > stall > increment.
   always_comb begin
      next_pc = pc_plus1;
      if (stall)  next_pc = pc_out;
      if (branch) next_pc = branch_address;
`ifdef PC_RAS_EN
      if (do_push) next_pc = branch_address;
      if (do_pop)  next_pc = stack[top - PTR_W'(1)];
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pc_out <= RESET_VAL;
      else        pc_out <= next_pc;
   end

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for pc: a queue-based reference model compared every
// cycle, plus directed literal checks along the way.
module tb_pc;

   localparam int ADDR_W = 9;
   localparam int DEPTH  = 4;
   localparam int MODULO = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [ADDR_W-1:0] branch_address = '0;
   logic              branch = 1'b0;
   logic              stall = 1'b0;
   logic [ADDR_W-1:0] pc_out;
   logic [ADDR_W-1:0] pc_plus1;
`ifdef PC_RAS_EN
   logic              call = 1'b0;
   logic              ret = 1'b0;
   logic              ras_empty;
   logic              ras_full;
`endif

   int passed = 0;
   int total = 0;
   int model_pc = 0;
   int model_stack[$];
   bit taken;
   bit compare_en = 1'b0;

   always #5 clk = ~clk;

   pc #(.ADDR_W(ADDR_W), .RESET_ADDR(0), .RAS_DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset(reset),
      .branch_address(branch_address),
      .branch(branch),
      .stall(stall),
`ifdef PC_RAS_EN
      .call(call),
      .ret(ret),
      .ras_empty(ras_empty),
      .ras_full(ras_full),
`endif
      .pc_out(pc_out),
      .pc_plus1(pc_plus1)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual == expected) passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic applyStimulus(input bit br, input int addr, input bit st);
      branch         = br;
      branch_address = ADDR_W'(addr);
      stall          = st;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Reference model: the stack is a queue whose front is the oldest entry.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         model_pc = 0;
         model_stack.delete();
      end else begin
         taken = 1'b0;
`ifdef PC_RAS_EN
         if (ret && model_stack.size() > 0) begin
            model_pc = model_stack.pop_back();
            taken = 1'b1;
         end else if (call) begin
            model_stack.push_back((model_pc + 1) % MODULO);
            if (model_stack.size() > DEPTH) void'(model_stack.pop_front());
            model_pc = int'(branch_address);
            taken = 1'b1;
         end
`endif
         if (!taken) begin
            if (branch)      model_pc = int'(branch_address);
            else if (!stall) model_pc = (model_pc + 1) % MODULO;
         end
      end
   end

   always @(negedge clk) begin
      if (compare_en) begin
         checkOutput("model_pc_out", int'(pc_out), model_pc);
         checkOutput("model_pc_plus1", int'(pc_plus1), (model_pc + 1) % MODULO);
`ifdef PC_RAS_EN
         checkOutput("model_ras_empty", int'(ras_empty), int'(model_stack.size() == 0));
         checkOutput("model_ras_full", int'(ras_full), int'(model_stack.size() == DEPTH));
`endif
      end
   end

   initial begin
      #1 reset = 1'b0;
      compare_en = 1'b1;
      #1 checkOutput("reset_pc", int'(pc_out), 0);
      checkOutput("reset_plus1", int'(pc_plus1), 1);
      tick();
      tick();
      reset = 1'b1;
      repeat (7) tick();
      checkOutput("count_to_7", int'(pc_out), 7);

      // Asynchronous reset between edges, then restart from zero.
      #1 reset = 1'b0;
      #1 checkOutput("async_reset", int'(pc_out), 0);
      tick();
      checkOutput("reset_hold", int'(pc_out), 0);
      reset = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         checkOutput("after_release", int'(pc_out), i);
      end

      applyStimulus(1'b1, 'h023, 1'b0);
      tick();
      checkOutput("branch_023", int'(pc_out), 'h023);
      applyStimulus(1'b0, 0, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         checkOutput("post_branch", int'(pc_out), 'h023 + i);
      end

      applyStimulus(1'b1, 5, 1'b0);
      tick();
      applyStimulus(1'b0, 0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("stall_hold", int'(pc_out), 5);
      end
      applyStimulus(1'b1, 'h100, 1'b1);
      tick();
      checkOutput("branch_over_stall", int'(pc_out), 'h100);

      applyStimulus(1'b1, 'h1FF, 1'b0);
      tick();
      checkOutput("wrap_top", int'(pc_out), 'h1FF);
      checkOutput("wrap_plus1", int'(pc_plus1), 0);
      applyStimulus(1'b0, 0, 1'b0);
      tick();
      checkOutput("wrap_zero", int'(pc_out), 0);
      tick();
      checkOutput("wrap_one", int'(pc_out), 1);

      // A branch pending when reset arrives must be discarded.
      applyStimulus(1'b1, 'h055, 1'b0);
      #1 reset = 1'b0;
      #1 checkOutput("abort_async", int'(pc_out), 0);
      tick();
      checkOutput("abort_hold", int'(pc_out), 0);
      applyStimulus(1'b0, 0, 1'b0);
      reset = 1'b1;
      tick();
      checkOutput("abort_restart", int'(pc_out), 1);

`ifdef PC_RAS_EN
      applyStimulus(1'b1, 'h010, 1'b0);
      tick();
      applyStimulus(1'b0, 'h080, 1'b0);
      call = 1'b1;
      tick();
      checkOutput("call_target", int'(pc_out), 'h080);
      checkOutput("call_not_empty", int'(ras_empty), 0);
      call = 1'b0;
      ret  = 1'b1;
      tick();
      checkOutput("ret_link", int'(pc_out), 'h011);
      ret  = 1'b0;
      call = 1'b1;
      for (int i = 0; i < 5; i++) begin
         branch_address = ADDR_W'('h020 + 'h010 * i);
         tick();
      end
      checkOutput("five_calls_pc", int'(pc_out), 'h060);
      checkOutput("five_calls_full", int'(ras_full), 1);
      call = 1'b0;
      ret  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("ret_unwind", int'(pc_out), 'h051 - 'h010 * i);
      end
      tick();
      checkOutput("ret_empty_incr", int'(pc_out), 'h022);
      checkOutput("ret_empty_flag", int'(ras_empty), 1);
      ret = 1'b0;
`endif

      tick();
      compare_en = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
